isl51002_cfg_sequencer: RTL and testbench
=========================================

// Module: isl51002_cfg_sequencer
// PURPOSE
// - Host-side configuration and lock controller for the ISL51002 capture frontend.
// - Holds shadow copies of the three hv_in_config words.
// - Applies a committed set atomically at the next frame boundary, so the frontend never sees a mixed timing set.
// - Qualifies input-mode stability from the frontend's vtotal, frame_change and interlace_flag.
// - Sits between the CPU register bank and isl51002_frontend.
// PARAMETERS
// - STABLE_FRAMES   default 4         consecutive in-tolerance frames needed for lock (range 2..15)
// - VTOTAL_TOL      default 1         allowed |vtotal - reference| in lines, still counts as in tolerance
// - TIMEOUT_CYCLES  default 4000000   PCLK cycles without a frame edge before the signal is declared lost
// PORTS
// - PCLK_i           in   1   pixel clock; the only clock
// - reset_n          in   1   asynchronous active-low reset
// - cfg_wr_i         in   1   shadow write strobe
// - cfg_addr_i       in   2   0=hv_in_config, 1=hv_in_config2, 2=hv_in_config3, 3=unused
// - cfg_wdata_i      in   32  shadow write data
// - cfg_commit_i     in   1   request apply of shadow set at next frame boundary
// - cfg_busy_o       out  1   commit pending; writes and commits are ignored while high
// - frame_change_i   in   1   frontend frame_change level (high for about one line per frame)
// - vtotal_i         in   11  frontend measured lines per frame
// - interlace_flag_i in   1   frontend interlace flag
// - hv_in_config_o   out  32  active config word 0, to frontend
// - hv_in_config2_o  out  32  active config word 1, to frontend
// - hv_in_config3_o  out  32  active config word 2, to frontend
// - mode_changed_o   out  1   1-cycle pulse when the active set is updated
// - sig_present_o    out  1   frame edges arriving (state != NOSIG)
// - sync_lock_o      out  1   mode stable (state == LOCKED)
// - lock_vtotal_o    out  11  reference vtotal used for qualification
// - unlock_count_o   out  8   LOCKED->ACQUIRE transitions; saturates at 255
// BEHAVIOUR
// - Reset values:
//   - All outputs, shadows, counters and state regs are 0; state = NOSIG.
// - Frame tick:
//   - frame_tick is a 1-cycle pulse, registered, one cycle after a 0->1 edge of frame_change_i.
//   - vtotal_i and interlace_flag_i are sampled on frame_tick.
// - Shadow writes:
//   - A write with cfg_busy_o=0 and addr 0..2 updates the shadow word on the next edge.
//   - addr 3 is dropped. Writes with cfg_busy_o=1 are dropped.
// - Commit:
//   - cfg_commit_i with cfg_busy_o=0 sets pending; cfg_busy_o goes high the next cycle.
//   - A write and a commit in the same cycle: the write is accepted and included in the commit.
// - Apply:
//   - Apply happens on the first frame_tick while pending, or on watchdog expiry while pending.
//   - On apply, all three active words load from the shadows on the same edge.
//   - Pending clears and mode_changed_o pulses for 1 cycle.
//   - Lock state is forced to ACQUIRE with ref = vtotal_i and cnt = 1 (on timeout: NOSIG).
//   - Latency: apply edge = tick edge; outputs are visible the following cycle.
// - Watchdog:
//   - Counts PCLK cycles and clears on frame_tick.
//   - On reaching TIMEOUT_CYCLES-1: state -> NOSIG, sync_lock_o=0, counter holds at the limit until the next tick.
// - In-tolerance test:
//   - 12-bit signed difference; |vtotal_i - ref| <= VTOTAL_TOL and interlace_flag_i == latched flag.
// - Lock FSM, evaluated on frame_tick:
//   - NOSIG: ref <= vtotal_i; flag latched; cnt <= 1; -> ACQUIRE.
//   - ACQUIRE, in tolerance: cnt++. When cnt+1 == STABLE_FRAMES -> LOCKED.
//   - ACQUIRE, out of tolerance: ref/flag reloaded, cnt <= 1.
//   - LOCKED, in tolerance: stay; ref is not updated (no drift tracking).
//   - LOCKED, out of tolerance: -> ACQUIRE; ref reloaded; cnt <= 1; unlock_count_o++ (saturating).
// - Priority when events coincide:
//   - Apply beats the FSM evaluation on the same tick.
//   - A watchdog expiry and a tick in the same cycle: the tick wins.
// - Reset mid-commit: pending is lost; active words return to 0.
// STRUCTURE
// - Shared package isl51002_cfg_pkg holds:
//   - state encoding (NOSIG=2'd0, ACQUIRE=2'd1, LOCKED=2'd2)
//   - CFG_ADDR_* constants
//   - saturating-increment helper
// - Sub-module isl51002_frame_watchdog: edge detect, frame_tick, timeout counter, expiry pulse.
// - Top level holds the shadow/active registers, commit logic and lock FSM.
// TESTING
// - Reset, then write 0x11111111/0x22222222/0x33333333 to addr 0/1/2 and commit, then a frame edge
//   -> all three hv_in_config outputs change on the same cycle; mode_changed_o high exactly 1 cycle;
//      cfg_busy_o falls on that cycle.
// - Frame edges with vtotal 525,525,526,525 (STABLE_FRAMES=4, TOL=1)
//   -> sync_lock_o rises after the 4th tick; lock_vtotal_o=525.
// - While locked, one frame with vtotal 625
//   -> sync_lock_o=0 one cycle after that tick; unlock_count_o=1; relock after 3 further frames of 625.
// - Stop frame edges for TIMEOUT_CYCLES (set to 1000 in the bench) with a commit pending
//   -> sig_present_o=0, sync_lock_o=0, shadows applied, mode_changed_o pulses.
// - Write to addr 1 while cfg_busy_o=1, plus a second commit
//   -> both ignored; applied word equals the value written before the first commit.
// - Toggle interlace_flag_i at constant vtotal while locked, then assert reset_n low mid-pending
//   -> lock is lost; after reset all outputs read 0 and cfg_busy_o=0.

Source files
------------

// File: rtl/isl51002_cfg_sequencer_pkg.sv
// Shared types and helpers for the ISL51002 configuration/lock sequencer.
package isl51002_cfg_pkg;

  typedef enum logic [1:0] {
    ST_NOSIG   = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

  localparam logic [1:0] CFG_ADDR_HV1    = 2'd0;
  localparam logic [1:0] CFG_ADDR_HV2    = 2'd1;
  localparam logic [1:0] CFG_ADDR_HV3    = 2'd2;
  localparam logic [1:0] CFG_ADDR_UNUSED = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/isl51002_cfg_sequencer_if.sv
// Host register bus plus frontend status/config signals of the sequencer.
interface isl51002_cfg_sequencer_if;
  logic        cfg_wr_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic        cfg_commit_i;
  logic        cfg_busy_o;
  logic        frame_change_i;
  logic [10:0] vtotal_i;
  logic        interlace_flag_i;
  logic [31:0] hv_in_config_o;
  logic [31:0] hv_in_config2_o;
  logic [31:0] hv_in_config3_o;
  logic        mode_changed_o;
  logic        sig_present_o;
  logic        sync_lock_o;
  logic [10:0] lock_vtotal_o;
  logic [7:0]  unlock_count_o;

  modport master (
    output cfg_wr_i, cfg_addr_i, cfg_wdata_i, cfg_commit_i,
    output frame_change_i, vtotal_i, interlace_flag_i,
    input  cfg_busy_o, hv_in_config_o, hv_in_config2_o, hv_in_config3_o,
    input  mode_changed_o, sig_present_o, sync_lock_o, lock_vtotal_o, unlock_count_o
  );

  modport slave (
    input  cfg_wr_i, cfg_addr_i, cfg_wdata_i, cfg_commit_i,
    input  frame_change_i, vtotal_i, interlace_flag_i,
    output cfg_busy_o, hv_in_config_o, hv_in_config2_o, hv_in_config3_o,
    output mode_changed_o, sig_present_o, sync_lock_o, lock_vtotal_o, unlock_count_o
  );
endinterface

// File: rtl/isl51002_cfg_sequencer_watchdog.sv
// Frame edge detector producing a registered frame_tick, plus a no-frame
// watchdog that emits a single expiry pulse and then holds until the next tick.
module isl51002_frame_watchdog #(
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_change,
  output logic frame_tick,
  output logic expire
);
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT    = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] LIMIT_M1 = W'(TIMEOUT_CYCLES - 2);

  logic         fc_d;
  logic [W-1:0] cnt;

  // expire is high for exactly the cycle in which the counter sits freshly at LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_d       <= 1'b0;
      frame_tick <= 1'b0;
      cnt        <= '0;
      expire     <= 1'b0;
    end else begin
      fc_d       <= frame_change;
      frame_tick <= frame_change & ~fc_d;
      expire     <= ~frame_tick & (cnt == LIMIT_M1);
      if (frame_tick) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/isl51002_cfg_sequencer.sv
// Shadow/active configuration registers with frame-aligned atomic apply,
// and the input-mode lock qualifier for the ISL51002 frontend.
module isl51002_cfg_sequencer
  import isl51002_cfg_pkg::*;
#(
  parameter int STABLE_FRAMES  = 4,
  parameter int VTOTAL_TOL     = 1,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input logic PCLK_i,
  input logic reset_n,
  isl51002_cfg_sequencer_if.slave bus
);
  localparam logic [3:0]  STABLE_CNT = 4'(STABLE_FRAMES);
  localparam logic [11:0] TOL12      = 12'(VTOTAL_TOL);

  logic        frame_tick;
  logic        expire;
  logic        apply;
  logic [31:0] shadow0, shadow1, shadow2;
  logic [31:0] active0, active1, active2;
  logic        pending_q;
  logic        mode_changed_q;

  lock_state_e state_q, state_d;
  logic [10:0] ref_q, ref_d;
  logic        flag_q, flag_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  unlock_q, unlock_d;

  logic signed [11:0] vdiff;
  logic [11:0]        vabs;
  logic               in_tol;

  isl51002_frame_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk         (PCLK_i),
    .rst_n       (reset_n),
    .frame_change(bus.frame_change_i),
    .frame_tick  (frame_tick),
    .expire      (expire)
  );

  assign apply = pending_q & (frame_tick | expire);

  // Writes land in the shadows before a same-cycle commit is latched, so they ride along
  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      shadow0        <= '0;
      shadow1        <= '0;
      shadow2        <= '0;
      active0        <= '0;
      active1        <= '0;
      active2        <= '0;
      pending_q      <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      mode_changed_q <= apply;
      if (apply) begin
        active0   <= shadow0;
        active1   <= shadow1;
        active2   <= shadow2;
        pending_q <= 1'b0;
      end else if (bus.cfg_commit_i) begin
        pending_q <= 1'b1;
      end
      if (bus.cfg_wr_i && !pending_q) begin
        case (bus.cfg_addr_i)
          CFG_ADDR_HV1:    shadow0 <= bus.cfg_wdata_i;
          CFG_ADDR_HV2:    shadow1 <= bus.cfg_wdata_i;
          CFG_ADDR_HV3:    shadow2 <= bus.cfg_wdata_i;
          CFG_ADDR_UNUSED: ;
          default:         ;
        endcase
      end
    end
  end

  assign vdiff  = $signed({1'b0, bus.vtotal_i}) - $signed({1'b0, ref_q});
  assign vabs   = vdiff[11] ? $unsigned(-vdiff) : $unsigned(vdiff);
  assign in_tol = (vabs <= TOL12) && (bus.interlace_flag_i == flag_q);

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_NOSIG;
      ref_q    <= '0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      unlock_q <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      unlock_q <= unlock_d;
    end
  end

  // An apply restarts qualification from the current frame; a tick outranks a same-cycle expiry
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    flag_d   = flag_q;
    cnt_d    = cnt_q;
    unlock_d = unlock_q;
    if (frame_tick) begin
      if (pending_q || (state_q != ST_ACQUIRE && state_q != ST_LOCKED) ||
          (state_q == ST_ACQUIRE && !in_tol)) begin
        state_d = ST_ACQUIRE;
        ref_d   = bus.vtotal_i;
        flag_d  = bus.interlace_flag_i;
        cnt_d   = 4'd1;
      end else if (state_q == ST_ACQUIRE) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q + 4'd1 == STABLE_CNT) begin
          state_d = ST_LOCKED;
        end
      end else if (!in_tol) begin
        state_d  = ST_ACQUIRE;
        ref_d    = bus.vtotal_i;
        flag_d   = bus.interlace_flag_i;
        cnt_d    = 4'd1;
        unlock_d = sat_inc8(unlock_q);
      end
    end else if (expire) begin
      state_d = ST_NOSIG;
    end
  end

  assign bus.cfg_busy_o      = pending_q;
  assign bus.hv_in_config_o  = active0;
  assign bus.hv_in_config2_o = active1;
  assign bus.hv_in_config3_o = active2;
  assign bus.mode_changed_o  = mode_changed_q;
  assign bus.sig_present_o   = (state_q != ST_NOSIG);
  assign bus.sync_lock_o     = (state_q == ST_LOCKED);
  assign bus.lock_vtotal_o   = ref_q;
  assign bus.unlock_count_o  = unlock_q;

endmodule

// File: tb/tb_isl51002_cfg_sequencer.sv
// Directed and randomized checks of isl51002_cfg_sequencer against a frame-level reference model.
module tb_isl51002_cfg_sequencer;
  localparam int STABLE = 4;
  localparam int TOL    = 1;
  localparam int TMO    = 1000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  isl51002_cfg_sequencer_if bus();

  isl51002_cfg_sequencer #(
    .STABLE_FRAMES (STABLE),
    .VTOTAL_TOL    (TOL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK_i (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_shadow [3];
  logic [31:0] m_active [3];
  bit m_pending, m_present, m_locked, m_flag;
  int m_ref, m_run, m_unlock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 0; m_present = 0; m_locked = 0; m_flag = 0;
    m_ref = 0; m_run = 0; m_unlock = 0;
  endfunction

  function automatic void model_start(input int vt, input bit il);
    m_ref = vt; m_flag = il; m_run = 1; m_locked = 0; m_present = 1;
  endfunction

  function automatic void model_apply();
    for (int i = 0; i < 3; i++) m_active[i] = m_shadow[i];
    m_pending = 0;
  endfunction

  function automatic void model_frame(input int vt, input bit il);
    bit ok;
    ok = (vt - m_ref <= TOL) && (m_ref - vt <= TOL) && (il == m_flag);
    if (m_pending) begin
      model_apply();
      model_start(vt, il);
    end else if (!m_present) begin
      model_start(vt, il);
    end else if (m_locked) begin
      if (!ok) begin
        if (m_unlock < 255) m_unlock++;
        model_start(vt, il);
      end
    end else if (ok) begin
      m_run++;
      if (m_run >= STABLE) m_locked = 1;
    end else begin
      model_start(vt, il);
    end
  endfunction

  function automatic void model_timeout();
    m_present = 0;
    m_locked  = 0;
    if (m_pending) model_apply();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit wr, input int addr, input logic [31:0] d, input bit commit);
    bus.cfg_wr_i     = wr;
    bus.cfg_addr_i   = 2'(addr);
    bus.cfg_wdata_i  = d;
    bus.cfg_commit_i = commit;
    step();
    bus.cfg_wr_i     = 1'b0;
    bus.cfg_commit_i = 1'b0;
    if (wr && !m_pending && addr < 3) m_shadow[addr] = d;
    if (commit && !m_pending) m_pending = 1;
  endtask

  task automatic send_frame(input int vt, input bit il);
    bus.vtotal_i         = 11'(vt);
    bus.interlace_flag_i = il;
    bus.frame_change_i   = 1'b1;
    repeat (3) step();
    bus.frame_change_i   = 1'b0;
    repeat (8) step();
    model_frame(vt, il);
  endtask

  task automatic check_all(input string tag);
    check_output({tag, ".hv0"}, bus.hv_in_config_o, m_active[0]);
    check_output({tag, ".hv1"}, bus.hv_in_config2_o, m_active[1]);
    check_output({tag, ".hv2"}, bus.hv_in_config3_o, m_active[2]);
    check_output({tag, ".busy"}, 32'(bus.cfg_busy_o), 32'(m_pending));
    check_output({tag, ".present"}, 32'(bus.sig_present_o), 32'(m_present));
    check_output({tag, ".lock"}, 32'(bus.sync_lock_o), 32'(m_locked));
    check_output({tag, ".refvt"}, 32'(bus.lock_vtotal_o), 32'(11'(m_ref)));
    check_output({tag, ".unlock"}, 32'(bus.unlock_count_o), 32'(m_unlock));
    check_output({tag, ".mchg"}, 32'(bus.mode_changed_o), 32'd0);
  endtask

  initial begin
    int vts [4];
    int mc_pulses;
    int r, vt;
    bit il;

    reset_n              = 1'b0;
    bus.cfg_wr_i         = 1'b0;
    bus.cfg_addr_i       = 2'd0;
    bus.cfg_wdata_i      = '0;
    bus.cfg_commit_i     = 1'b0;
    bus.frame_change_i   = 1'b0;
    bus.vtotal_i         = '0;
    bus.interlace_flag_i = 1'b0;
    model_reset();
    repeat (3) step();
    check_all("reset");
    reset_n = 1'b1;
    step();

    // Atomic apply at a frame boundary, with cycle-level timing
    apply_stimulus(1, 0, 32'h11111111, 0);
    apply_stimulus(1, 1, 32'h22222222, 0);
    apply_stimulus(1, 2, 32'h33333333, 0);
    check_output("pre_commit.hv0", bus.hv_in_config_o, 32'h0);
    apply_stimulus(0, 0, 32'h0, 1);
    check_output("commit.busy", 32'(bus.cfg_busy_o), 32'd1);
    bus.vtotal_i       = 11'd500;
    bus.frame_change_i = 1'b1;
    step();
    check_output("tick.hv0_old", bus.hv_in_config_o, 32'h0);
    check_output("tick.busy", 32'(bus.cfg_busy_o), 32'd1);
    check_output("tick.mchg", 32'(bus.mode_changed_o), 32'd0);
    step();
    check_output("apply.hv0", bus.hv_in_config_o, 32'h11111111);
    check_output("apply.hv1", bus.hv_in_config2_o, 32'h22222222);
    check_output("apply.hv2", bus.hv_in_config3_o, 32'h33333333);
    check_output("apply.mchg", 32'(bus.mode_changed_o), 32'd1);
    check_output("apply.busy", 32'(bus.cfg_busy_o), 32'd0);
    step();
    check_output("apply.mchg_end", 32'(bus.mode_changed_o), 32'd0);
    bus.frame_change_i = 1'b0;
    repeat (8) step();
    model_frame(500, 0);
    check_all("apply_done");

    // Acquire and lock with a one-line wobble inside tolerance
    vts = '{525, 525, 526, 525};
    foreach (vts[i]) begin
      send_frame(vts[i], 0);
      check_all("acquire");
    end
    check_output("lock.sync", 32'(bus.sync_lock_o), 32'd1);
    check_output("lock.refvt", 32'(bus.lock_vtotal_o), 32'd525);

    // Mode change while locked, then relock on the new mode
    send_frame(625, 0);
    check_all("unlock");
    check_output("unlock.sync", 32'(bus.sync_lock_o), 32'd0);
    check_output("unlock.count", 32'(bus.unlock_count_o), 32'd1);
    repeat (3) send_frame(625, 0);
    check_all("relock");
    check_output("relock.sync", 32'(bus.sync_lock_o), 32'd1);

    // Signal loss with a commit pending
    apply_stimulus(1, 0, 32'h44444444, 0);
    apply_stimulus(1, 1, 32'h55555555, 0);
    apply_stimulus(1, 2, 32'h66666666, 1);
    mc_pulses = 0;
    for (int i = 0; i < TMO + 100; i++) begin
      step();
      if (bus.mode_changed_o === 1'b1) mc_pulses++;
    end
    model_timeout();
    check_all("timeout");
    check_output("timeout.present", 32'(bus.sig_present_o), 32'd0);
    check_output("timeout.hv2", bus.hv_in_config3_o, 32'h66666666);
    check_output("timeout.mchg_pulses", 32'(mc_pulses), 32'd1);

    // Writes and commits while busy are dropped
    apply_stimulus(1, 1, 32'hAAAAAAAA, 0);
    apply_stimulus(0, 0, 32'h0, 1);
    apply_stimulus(1, 1, 32'hBBBBBBBB, 0);
    apply_stimulus(0, 0, 32'h0, 1);
    check_output("busy_drop.busy", 32'(bus.cfg_busy_o), 32'd1);
    send_frame(700, 0);
    check_all("busy_drop");
    check_output("busy_drop.hv1", bus.hv_in_config2_o, 32'hAAAAAAAA);
    send_frame(700, 0);
    check_all("busy_drop.second");
    repeat (2) send_frame(700, 0);
    check_output("lock700.sync", 32'(bus.sync_lock_o), 32'd1);

    // Interlace toggle breaks lock; reset in the middle of a pending commit
    send_frame(700, 1);
    check_all("interlace");
    check_output("interlace.sync", 32'(bus.sync_lock_o), 32'd0);
    check_output("interlace.count", 32'(bus.unlock_count_o), 32'd2);
    apply_stimulus(1, 0, 32'h77777777, 1);
    check_output("midreset.busy_pre", 32'(bus.cfg_busy_o), 32'd1);
    reset_n = 1'b0;
    #2;
    check_output("midreset.busy", 32'(bus.cfg_busy_o), 32'd0);
    check_output("midreset.hv0", bus.hv_in_config_o, 32'h0);
    model_reset();
    repeat (2) step();
    check_all("reset2");
    reset_n = 1'b1;
    step();

    // Write and commit in one cycle: the write is part of the applied set
    apply_stimulus(1, 2, 32'h12345678, 1);
    send_frame(400, 0);
    check_all("wr_commit");
    check_output("wr_commit.hv2", bus.hv_in_config3_o, 32'h12345678);

    // Randomized traffic
    il = 0;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        apply_stimulus(1, int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0));
      end else if (r == 4) begin
        apply_stimulus(0, 0, 32'h0, 1);
      end else begin
        vt = 600 + int'($urandom_range(0, 4)) - 2;
        if ($urandom_range(0, 9) == 0) il = ~il;
        send_frame(vt, il);
      end
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
